// File: rtl/axis_packetizer_if.sv
// AXI-Stream link bundle for axis_packetizer: upstream (s_axis_*) and downstream (m_axis_*) channels.
// The slave modport is the packetizer's view; the master modport is the surrounding environment's view.
interface axis_packetizer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tdata,
        output s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/axis_packetizer.sv
// axis_packetizer: groups every PKT_LEN upstream beats into a packet and marks the last beat with tlast.
// Output is a two-entry registered pipeline (output register + skid register), so s_axis_tready never
// depends combinationally on m_axis_tready.
// Optional feature macro: AXIS_PACKETIZER_CHECKSUM_EN appends a 32-bit additive checksum beat per packet.
module axis_packetizer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PKT_LEN    = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    axis_packetizer_if.slave     bus,
    output logic [CNT_WIDTH-1:0] pkt_count
);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(PKT_LEN - 1);

    logic [CNT_WIDTH-1:0]  beat_cnt;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  skid_last;
    logic                  skid_valid;

    logic                  in_ready;
    logic                  accept;
    logic                  drain;
    logic                  push_valid;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  push_last;

    assign accept = bus.s_axis_tvalid & in_ready;
    assign drain  = out_valid & bus.m_axis_tready;

`ifdef AXIS_PACKETIZER_CHECKSUM_EN
    typedef enum logic {
        PAYLOAD = 1'b0,
        CSUM    = 1'b1
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] sum;
    logic                  inject;

    // Checksum beat enters the pipeline as soon as the skid slot is free.
    assign in_ready   = ~skid_valid & (state == PAYLOAD) & ~reset;
    assign inject     = (state == CSUM) & ~skid_valid;
    assign push_valid = accept | inject;
    assign push_data  = inject ? sum : bus.s_axis_tdata;
    assign push_last  = inject;

    // Framing FSM: count payload beats, accumulate the sum, then emit one checksum beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= PAYLOAD;
            beat_cnt <= '0;
            sum      <= '0;
        end else begin
            case (state)
                PAYLOAD: begin
                    if (accept) begin
                        sum <= sum + bus.s_axis_tdata;
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= CSUM;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                CSUM: begin
                    if (inject) begin
                        sum   <= '0;
                        state <= PAYLOAD;
                    end
                end
                default: state <= PAYLOAD;
            endcase
        end
    end
`else
    assign in_ready   = ~skid_valid & ~reset;
    assign push_valid = accept;
    assign push_data  = bus.s_axis_tdata;
    assign push_last  = (beat_cnt == LAST_BEAT);

    // Payload beat counter; wraps after the tlast beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beat_cnt <= '0;
        end else if (accept) begin
            if (beat_cnt == LAST_BEAT) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            end
        end
    end
`endif

    // Two-entry output pipeline: skid refills the output register first, new beats go to whichever is free.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_data   <= '0;
            out_last   <= 1'b0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || drain) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_last   <= skid_last;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (push_valid) begin
                out_data  <= push_data;
                out_last  <= push_last;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (push_valid) begin
            skid_data  <= push_data;
            skid_last  <= push_last;
            skid_valid <= 1'b1;
        end
    end

    // Completed-packet counter: one per tlast handshake at the output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_count <= '0;
        end else if (drain && out_last) begin
            pkt_count <= pkt_count + CNT_WIDTH'(1);
        end
    end

    assign bus.s_axis_tready = in_ready;
    assign bus.m_axis_tdata  = out_data;
    assign bus.m_axis_tlast  = out_last;
    assign bus.m_axis_tvalid = out_valid;
endmodule

// File: tb/tb_axis_packetizer.sv
// Scoreboard bench for axis_packetizer: accepted input beats feed a packet-level reference model that
// queues the expected output stream; an independent output monitor pops and compares on every handshake.
module tb_axis_packetizer;
    localparam int unsigned PKT_LEN   = 4;
    localparam int unsigned CNT_WIDTH = 16;
`ifdef AXIS_PACKETIZER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [CNT_WIDTH-1:0] pkt_count;

    axis_packetizer_if #(.DATA_WIDTH(32)) bus ();

    axis_packetizer #(
        .DATA_WIDTH(32),
        .PKT_LEN   (PKT_LEN),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .pkt_count(pkt_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          stamp;
        bit          payload;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] pkt_buf[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          pkts_exp = 0;
    int          lo_cnt = 0;
    int          rst_epoch = 0;
    bit          lat_chk = 1'b0;
    bit          lo_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Reference model: a packet is PKT_LEN payload words, optionally followed by their 32-bit sum.
    task automatic model_accept(input logic [31:0] d);
        exp_t        e;
        logic [31:0] s;
        pkt_buf.push_back(d);
        e.data    = d;
        e.last    = !CSUM_EN && (pkt_buf.size() == int'(PKT_LEN));
        e.stamp   = cyc;
        e.payload = 1'b1;
        exp_q.push_back(e);
        if (pkt_buf.size() == int'(PKT_LEN)) begin
            if (CSUM_EN) begin
                s = 32'd0;
                foreach (pkt_buf[i]) s = s + pkt_buf[i];
                e.data    = s;
                e.last    = 1'b1;
                e.payload = 1'b0;
                exp_q.push_back(e);
            end
            pkts_exp++;
            pkt_buf.delete();
        end
    endtask

    always @(posedge clock) cyc++;

    // Input side: record accepted beats and count cycles with s_axis_tready low.
    always @(negedge clock) begin
        if (!reset && bus.s_axis_tvalid && bus.s_axis_tready) model_accept(bus.s_axis_tdata);
        if (lo_en && !bus.s_axis_tready) lo_cnt++;
    end

    logic        stall_prev = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    int          prev_epoch = 0;

    // Output side: hold-stable check under backpressure and in-order scoreboard compare.
    always @(negedge clock) begin
        exp_t e;
        if (stall_prev && prev_epoch == rst_epoch) begin
            chk("hold_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
            chk("hold_tdata", bus.m_axis_tdata, prev_data);
            chk("hold_tlast", 32'(bus.m_axis_tlast), 32'(prev_last));
        end
        stall_prev = bus.m_axis_tvalid && !bus.m_axis_tready;
        prev_data  = bus.m_axis_tdata;
        prev_last  = bus.m_axis_tlast;
        prev_epoch = rst_epoch;
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got data %0h tlast %0b with nothing queued",
                         bus.m_axis_tdata, bus.m_axis_tlast);
            end else begin
                e = exp_q.pop_front();
                chk("out_tdata", bus.m_axis_tdata, e.data);
                chk("out_tlast", 32'(bus.m_axis_tlast), 32'(e.last));
                if (lat_chk && e.payload) chk("latency", 32'(cyc - e.stamp), 32'd1);
            end
        end
    end

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic cycle_drive(input logic v, input logic [31:0] d, input logic r, output logic acc);
        bus.s_axis_tvalid = v;
        bus.s_axis_tdata  = d;
        bus.m_axis_tready = r;
        @(negedge clock);
        acc = v & bus.s_axis_tready;
        @(posedge clock);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic r);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) cycle_drive(1'b1, d, r, acc);
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int t = 0; t < n; t++) cycle_drive(1'b0, 32'd0, 1'b1, acc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   acc_n;
        int   after_drop;
        int   sent;
        int   base;
        logic v;
        logic r;

        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.m_axis_tready = 1'b0;

        // Reset values
        repeat (2) @(posedge clock);
        #1;
        chk("reset_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        chk("reset_tdata", bus.m_axis_tdata, 32'd0);
        chk("reset_tlast", 32'(bus.m_axis_tlast), 32'd0);
        chk("reset_pkt_count", 32'(pkt_count), 32'd0);
        chk("reset_s_ready", 32'(bus.s_axis_tready), 32'd0);
        reset = 1'b0;
        #1;
        chk("s_ready_after_reset", 32'(bus.s_axis_tready), 32'd1);
        @(posedge clock);
        #1;

        // Back-to-back 1..8 with the sink always ready
        lat_chk = 1'b1;
        lo_en   = 1'b1;
        lo_cnt  = 0;
        for (int i = 1; i <= 8; i++) send_beat(32'(i), 1'b1);
        idle(4);
        lo_en   = 1'b0;
        lat_chk = 1'b0;
        chk("s_ready_low_cycles", 32'(lo_cnt), CSUM_EN ? 32'd2 : 32'd0);
        chk("pkt_count_seq", 32'(pkt_count), 32'd2);
        chk("drained_seq", 32'(exp_q.size()), 32'd0);

        // Checksum wrap-around packet
        send_beat(32'hFFFF_FFFF, 1'b1);
        send_beat(32'h0000_0002, 1'b1);
        send_beat(32'h0000_0000, 1'b1);
        send_beat(32'h0000_0000, 1'b1);
        idle(4);
        chk("pkt_count_wrap", 32'(pkt_count), 32'(pkts_exp));

        // Backpressure: sink stalls for 5 cycles while the source keeps offering beats
        acc_n      = 0;
        after_drop = 0;
        for (int c = 0; c < 200 && acc_n < 12; c++) begin
            r = !(c >= 3 && c < 8);
            cycle_drive(1'b1, 32'h100 + 32'(acc_n), r, acc);
            if (acc) begin
                acc_n++;
                if (!r) after_drop++;
            end
        end
        chk("bp_beats_sent", 32'(acc_n), 32'd12);
        chk("bp_accepted_le2", 32'(after_drop <= 2), 32'd1);
        idle(6);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);
        chk("pkt_count_bp", 32'(pkt_count), 32'(pkts_exp));

        // Reset mid-packet with beats parked in the pipeline
        cycle_drive(1'b1, 32'hA0, 1'b0, acc);
        cycle_drive(1'b1, 32'hA1, 1'b0, acc);
        bus.s_axis_tvalid = 1'b0;
        #1;
        reset = 1'b1;
        rst_epoch++;
        #1;
        chk("midrst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        chk("midrst_tdata", bus.m_axis_tdata, 32'd0);
        chk("midrst_tlast", 32'(bus.m_axis_tlast), 32'd0);
        chk("midrst_pkt_count", 32'(pkt_count), 32'd0);
        chk("midrst_s_ready", 32'(bus.s_axis_tready), 32'd0);
        exp_q.delete();
        pkt_buf.delete();
        pkts_exp = 0;
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_s_ready_release", 32'(bus.s_axis_tready), 32'd1);
        @(posedge clock);
        #1;
        for (int i = 10; i <= 13; i++) send_beat(32'(i), 1'b1);
        idle(4);
        chk("midrst_drained", 32'(exp_q.size()), 32'd0);
        chk("midrst_pkt_count_after", 32'(pkt_count), 32'd1);

        // Random valid/ready at 50% each
        base = pkts_exp;
        sent = 0;
        for (int c = 0; c < 80000 && sent < 10000; c++) begin
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            cycle_drive(v, $urandom, r, acc);
            if (acc) sent++;
        end
        chk("random_sent", 32'(sent), 32'd10000);
        idle(8);
        chk("random_drained", 32'(exp_q.size()), 32'd0);
        chk("random_pkt_count", 32'(pkt_count), 32'(CNT_WIDTH'(base + 10000 / int'(PKT_LEN))));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
